ahb_sram_slave: RTL
===================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data width; only 32 is supported.
REQ-002 The block SHALL have parameter AW, default 32, meaning address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning memory size in 32-bit words.
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 0, meaning wait states inserted per valid transfer (0..15).
REQ-005 The block SHALL have port hclk, input, 1 bit, the only clock; all state changes on its rising edge.
REQ-006 The block SHALL have port hreset_n, input, 1 bit, reset, asynchronous assert and active-low.
REQ-007 The block SHALL have port hsel, input, 1 bit, slave select.
REQ-008 The block SHALL have port haddr, input, AW bits, byte address.
REQ-009 The block SHALL have port htrans, input, 2 bits, with encoding IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-010 The block SHALL have port hsize, input, 3 bits, with encoding 0=byte, 1=halfword, 2=word.
REQ-011 The block SHALL have port hwrite, input, 1 bit, where 1 means write.
REQ-012 The block SHALL have port hwdata, input, DW bits, carrying write data, valid in the data phase.
REQ-013 The block SHALL have port hready, input, 1 bit, the bus-level ready (previous transfer complete).
REQ-014 The block SHALL have port hreadyout, output, 1 bit, meaning this slave is ready or its transfer is complete.
REQ-015 The block SHALL have port hresp, output, 1 bit, where 0 means OKAY and 1 means ERROR.
REQ-016 The block SHALL have port hrdata, output, DW bits, carrying read data.

Function
REQ-017 The block SHALL accept an address phase only when hsel=1, hready=1 and htrans[1]=1 are all true at the clock edge; it SHALL register the address, size and direction at that edge.
REQ-018 When hsel=1, hready=1 and htrans is IDLE or BUSY, the block SHALL return zero-wait OKAY: hreadyout=1, hresp=0, no memory access.
REQ-019 The block SHALL flag an accepted transfer as an error if any of the following holds: word index haddr[AW-1:2] >= DEPTH; hsize > 2; halfword with haddr[0]=1; word with haddr[1:0]!=0.
REQ-020 The block SHALL implement a state machine with states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-021 IDLE -> WAIT on accept when WAIT_CYCLES>0; IDLE -> DATA on accept when WAIT_CYCLES=0; IDLE -> ERR1 on an error transfer, with no wait states.
REQ-022 In WAIT, the block SHALL drive hreadyout=0 and hresp=0, and count down WAIT_CYCLES cycles, then go to DATA.
REQ-023 In DATA, the block SHALL drive hreadyout=1 and hresp=0; a write SHALL commit at the end of this cycle; a new accept in the same cycle (pipelined) SHALL be processed per REQ-021.
REQ-024 In ERR1, the block SHALL drive hreadyout=0 and hresp=1, then go to ERR2.
REQ-025 In ERR2, the block SHALL drive hreadyout=1 and hresp=1; an address phase presented in ERR2 SHALL be accepted normally.
REQ-026 Errored transfers SHALL NOT modify memory.
REQ-027 Write byte lanes SHALL be little-endian.
- byte: lane haddr[1:0].
- halfword: lanes {haddr[1],0} and {haddr[1],1}.
- word: all lanes.
- Other lanes SHALL be left unchanged.
REQ-028 hrdata SHALL equal the full word mem[registered index] while in DATA for a read, and 0 otherwise; the master extracts sub-word lanes.
REQ-029 A read accepted in the same cycle that a write completes to the same word SHALL return the newly written data (read-after-write ordering).
REQ-030 hwdata SHALL be sampled only in the completing DATA cycle of a write.

Reset
REQ-031 While hreset_n=0, the block SHALL hold state IDLE with hreadyout=1, hresp=0, hrdata=0 and the wait counter at 0.
REQ-032 Reset asserted mid-transfer SHALL discard the transfer with no memory write; memory contents are not reset.
REQ-033 On the first edge after reset deassertion, the block SHALL be able to accept an address phase.

Verification
REQ-034 The bench SHALL cover this scenario: with WAIT_CYCLES=0, word write 0x0000_0010 <- 0xDEADBEEF, then a pipelined word read of 0x10 -> the read data phase has hreadyout=1, hrdata=0xDEADBEEF, and hresp=0.
REQ-035 The bench SHALL cover this scenario: byte write 0xAA to 0x13 over a word preset to 0x11223344 -> a word read of 0x10 returns 0xAA223344.
REQ-036 The bench SHALL cover this scenario: with WAIT_CYCLES=2, a read of 0x10 -> hreadyout is low for exactly 2 cycles, then high with the data.
REQ-037 The bench SHALL cover this scenario: a word read at 0x400 (index 256, DEPTH=256) -> the error cycle shows hreadyout=0/hresp=1, then hreadyout=1/hresp=1, and memory is unchanged.
REQ-038 The bench SHALL cover this scenario: a misaligned halfword write at 0x11 -> a two-cycle ERROR, and a subsequent read of 0x10 returns the old value.
REQ-039 The bench SHALL cover this scenario: hreset_n pulsed low during the WAIT state of a write to 0x20 -> outputs immediately return to reset values and mem[8] is unchanged.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with byte lanes,
// optional wait states and two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          hclk,
    input  logic          hreset_n,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hsize,
    input  logic          hwrite,
    input  logic [DW-1:0] hwdata,
    input  logic          hready,
    output logic          hreadyout,
    output logic          hresp,
    output logic [DW-1:0] hrdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);
    localparam logic [3:0] WLOAD =
        4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    be_q, be_d;
    logic          wr_q, wr_d;

    logic [DW-1:0] mem [DEPTH];

    logic          accept;
    logic          err;
    logic [AW-1:0] widx;
    logic [3:0]    be_a;
    logic          unused_trans0;

    assign unused_trans0 = htrans[0];

    // BUSY and IDLE have htrans[1]=0 and are never accepted
    assign accept = hsel & hready & htrans[1];

    assign widx = {2'b00, haddr[AW-1:2]};

    assign err = (widx >= DEPTH_W)
               | (hsize > 3'd2)
               | ((hsize == 3'd1) & haddr[0])
               | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

    // Little-endian byte-lane enables for the incoming transfer
    always_comb begin
        be_a = 4'b0000;
        unique case (hsize)
            3'd0:    be_a = 4'b0001 << haddr[1:0];
            3'd1:    be_a = haddr[1] ? 4'b1100 : 4'b0011;
            default: be_a = 4'b1111;
        endcase
    end

    // Next-state logic; new transfers only start when hreadyout is high
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        be_d    = be_q;
        wr_d    = wr_q;
        unique case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (err) begin
                        state_d = S_ERR1;
                    end else begin
                        idx_d = haddr[IW+1:2];
                        be_d  = be_a;
                        wr_d  = hwrite;
                        if (WAIT_CYCLES > 0) begin
                            state_d = S_WAIT;
                            cnt_d   = WLOAD;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            be_q    <= 4'b0000;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
        end
    end

    // Write commits at the end of the DATA cycle; contents survive reset
    always_ff @(posedge hclk) begin
        if (state_q == S_DATA && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    assign hreadyout = (state_q != S_WAIT) && (state_q != S_ERR1);
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign hrdata    = (state_q == S_DATA && !wr_q) ? mem[idx_q] : '0;

endmodule
